// File: rtl/skew_feed_pkg.sv
// Shared types and sizing helpers for the skew feed controller slice.
package skew_feed_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int unsigned DEF_R = 2;
  localparam int unsigned DEF_S = 8;
  localparam int unsigned DEF_N = 2;
  localparam int unsigned DEF_D = 3;

  localparam int unsigned STREAM_LEN = DEF_S + DEF_R - 1;

  function automatic int unsigned stream_len(input int unsigned s, input int unsigned r);
    return s + r - 1;
  endfunction

  // Counter must hold both the stream index and the drain index.
  function automatic int unsigned cnt_width(input int unsigned s, input int unsigned r,
                                            input int unsigned d);
    int unsigned m;
    m = (s + r - 1 > d) ? (s + r - 1) : d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/skew_window_cmp.sv
// Per-lane window comparator: en is high while LANE <= c < LANE+S during STREAM.
module skew_window_cmp #(
  parameter int unsigned CW   = 4,
  parameter int unsigned S    = 8,
  parameter int unsigned LANE = 0
) (
  input  logic [CW-1:0] c,
  input  logic          active,
  output logic          en
);

  localparam logic [CW-1:0] LO  = CW'(LANE);
  localparam logic [CW-1:0] LEN = CW'(S);

  logic [CW:0] diff;

  // Offset from the lane start; the borrow bit flags c < LANE.
  always_comb begin
    diff = {1'b0, c} - {1'b0, LO};
    en   = active && !diff[CW] && (diff[CW-1:0] < LEN);
  end

endmodule

// File: rtl/skew_feed_controller.sv
// Operand feeder sequencer: load, diagonal-skewed shift enables, drain, done.
// Optional op_count output enabled by macro SKEW_FEED_OPCOUNT_EN.
module skew_feed_controller
  import skew_feed_pkg::*;
#(
  parameter int unsigned R = DEF_R,
  parameter int unsigned S = DEF_S,
  parameter int unsigned N = DEF_N,
  parameter int unsigned D = DEF_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [R*S*N-1:0] in_data,
  output logic [R-1:0]     load,
  output logic [R*S*N-1:0] load_data,
  output logic [R-1:0]     enable,
  output logic             busy,
  output logic             done
`ifdef SKEW_FEED_OPCOUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  localparam int unsigned SLEN = stream_len(S, R);
  localparam int unsigned CW   = cnt_width(S, R, D);
  localparam logic [CW-1:0] STREAM_LAST = CW'(SLEN - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'((D == 0) ? 0 : D - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [R-1:0]  en_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      load_data <= '0;
    else if (state == IDLE && start)
      load_data <= in_data;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = STREAM;
        cnt_nxt   = '0;
      end
      STREAM: begin
        if (cnt == STREAM_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (D == 0) ? DONE : DRAIN;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar r = 0; r < R; r++) begin : g_lane
    skew_window_cmp #(
      .CW  (CW),
      .S   (S),
      .LANE(r)
    ) u_cmp (
      .c     (cnt),
      .active(state == STREAM),
      .en    (en_w[r])
    );
  end

  always_comb begin
    ready  = (state == IDLE);
    busy   = (state != IDLE);
    done   = (state == DONE);
    load   = (state == LOAD) ? '1 : '0;
    enable = en_w;
  end

`ifdef SKEW_FEED_OPCOUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      op_count <= '0;
    else if (state == DONE)
      op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_skew_feed_controller.sv
// Scoreboard bench for skew_feed_controller (D=3 instance plus a D=0 instance).
module tb_skew_feed_controller;

  localparam int R = 2;
  localparam int S = 8;
  localparam int N = 2;
  localparam int D = 3;
  localparam int W = R * S * N;

  logic clk = 1'b0;
  logic rst, start, start0;
  logic [W-1:0] in_data;

  logic ready, busy, done, ready0, busy0, done0;
  logic [R-1:0] load, enable, load0, enable0;
  logic [W-1:0] load_data, load_data0;
`ifdef SKEW_FEED_OPCOUNT_EN
  logic [15:0] op_count, op_count0;
`endif

  always #5 clk = ~clk;

  skew_feed_controller #(.R(R), .S(S), .N(N), .D(D)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .in_data(in_data),
    .load(load), .load_data(load_data), .enable(enable), .busy(busy), .done(done)
`ifdef SKEW_FEED_OPCOUNT_EN
    , .op_count(op_count)
`endif
  );

  skew_feed_controller #(.R(R), .S(S), .N(N), .D(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .ready(ready0), .in_data(in_data),
    .load(load0), .load_data(load_data0), .enable(enable0), .busy(busy0), .done(done0)
`ifdef SKEW_FEED_OPCOUNT_EN
    , .op_count(op_count0)
`endif
  );

  typedef struct packed {
    logic         ready;
    logic         busy;
    logic         done;
    logic [1:0]   load;
    logic [1:0]   enable;
    logic [31:0]  ld;
  } snap_t;

  snap_t sb[$];
  int checks = 0;
  int failures = 0;

  // k = cycles after the accept cycle; k=0 or past the end means idle.
  function automatic snap_t exp_at(input int k, input logic [31:0] d, input int dd);
    snap_t e;
    e = '{ready: 1'b1, busy: 1'b0, done: 1'b0, load: 2'b00, enable: 2'b00, ld: d};
    if (k == 1) begin
      e.ready = 1'b0; e.busy = 1'b1; e.load = 2'b11;
    end else if (k >= 2 && k <= S + R) begin
      int c = k - 2;
      e.ready = 1'b0; e.busy = 1'b1;
      for (int r = 0; r < R; r++) e.enable[r] = (c >= r) && (c < r + S);
    end else if (k > S + R && k <= S + R + dd) begin
      e.ready = 1'b0; e.busy = 1'b1;
    end else if (k == S + R + dd + 1) begin
      e.ready = 1'b0; e.busy = 1'b1; e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic snap_t obs3();
    return {ready, busy, done, load, enable, load_data};
  endfunction

  function automatic snap_t obs0();
    return {ready0, busy0, done0, load0, enable0, load_data0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t e, o;
    rst = 1'b1; start = 1'b0; start0 = 1'b0; in_data = '0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      e = exp_at(0, 32'h0, D);
      o = obs3();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_idle i=%0d got=%h exp=%h", i, o, e);
      end
      o = obs0();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_idle_d0 i=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_schedule();
    snap_t e, o;
    int n0, n1, f0, f1;
    logic [31:0] d;
    d = 32'hA5A5_3C3C;
    n0 = 0; n1 = 0; f0 = -1; f1 = -1;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL sched_ready_t0 got=%b exp=1", ready);
    end
    in_data = d; start = 1'b1;
    for (int k = 1; k <= 15; k++) sb.push_back(exp_at(k, d, D));
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 1) start = 1'b0;
      e = sb.pop_front();
      o = obs3();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL sched k=%0d got=%h exp=%h", k, o, e);
      end
      if (enable[0] === 1'b1) begin n0++; if (f0 < 0) f0 = k; end
      if (enable[1] === 1'b1) begin n1++; if (f1 < 0) f1 = k; end
    end
    checks++;
    if (n0 != S) begin failures++; $display("FAIL lane0_enables got=%0d exp=%0d", n0, S); end
    checks++;
    if (n1 != S) begin failures++; $display("FAIL lane1_enables got=%0d exp=%0d", n1, S); end
    checks++;
    if (f0 != 2) begin failures++; $display("FAIL lane0_first got=%0d exp=2", f0); end
    checks++;
    if (f1 - f0 != 1) begin failures++; $display("FAIL lane_skew got=%0d exp=1", f1 - f0); end
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    logic [31:0] d1, d2;
    d1 = 32'h1111_0000;
    d2 = 32'h2222_0000 + 32'd15;
    in_data = d1; start = 1'b1;
    for (int k = 1; k <= 15; k++) sb.push_back(exp_at(k, d1, D));
    for (int k = 1; k <= 15; k++) sb.push_back(exp_at(k, d2, D));
    for (int k = 1; k <= 30; k++) begin
      step();
      in_data = 32'h2222_0000 + 32'(k);
      if (k >= 16) start = 1'b0;
      e = sb.pop_front();
      o = obs3();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b k=%0d got=%h exp=%h", k, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    snap_t e, o;
    logic [31:0] d, d2;
    d = 32'h5A5A_C3C3;
    d2 = 32'h0F0F_F0F0;
    in_data = d; start = 1'b1;
    for (int k = 1; k <= 6; k++) sb.push_back(exp_at(k, d, D));
    sb.push_back(exp_at(0, 32'h0, D));
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) start = 1'b0;
      if (k == 7) rst = 1'b0;
      e = sb.pop_front();
      o = obs3();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rst_mid k=%0d got=%h exp=%h", k, o, e);
      end
      if (k == 6) rst = 1'b1;
    end
    in_data = d2; start = 1'b1;
    for (int k = 1; k <= 15; k++) sb.push_back(exp_at(k, d2, D));
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 1) start = 1'b0;
      e = sb.pop_front();
      o = obs3();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rst_rerun k=%0d got=%h exp=%h", k, o, e);
      end
    end
  endtask

  task automatic test_drain0();
    snap_t e, o;
    logic [31:0] d;
    d = 32'hC0DE_1234;
    in_data = d; start0 = 1'b1;
    for (int k = 1; k <= 12; k++) sb.push_back(exp_at(k, d, 0));
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) start0 = 1'b0;
      e = sb.pop_front();
      o = obs0();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL drain0 k=%0d got=%h exp=%h", k, o, e);
      end
    end
  endtask

`ifdef SKEW_FEED_OPCOUNT_EN
  task automatic test_opcount();
    rst = 1'b1; step(); rst = 1'b0;
    for (int op = 0; op < 3; op++) begin
      start = 1'b1; in_data = 32'(op);
      step();
      start = 1'b0;
      for (int k = 2; k <= 15; k++) step();
    end
    checks++;
    if (op_count !== 16'd3) begin
      failures++;
      $display("FAIL opcount_three got=%0d exp=3", op_count);
    end
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (op_count !== 16'd0) begin
      failures++;
      $display("FAIL opcount_reset got=%0d exp=0", op_count);
    end
  endtask
`endif

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_schedule();
    test_back_to_back();
    test_reset_mid();
    test_drain0();
`ifdef SKEW_FEED_OPCOUNT_EN
    test_opcount();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/skew_feed_controller.md
Name: skew_feed_controller

Overview:
- Upstream sequencer for the systolic multiplier's operand feeders.
- Accepts one packed operand block per handshake and loads it into R ring-shift feeder lanes in parallel.
- Then drives each lane's shift enable with a one-cycle-per-lane diagonal skew, so element k of lane r enters the array at stream cycle r+k.
- Waits a fixed drain interval for the array to settle, then signals completion.

Parameters:
- R, 2, number of feeder lanes (array rows or columns).
- S, 8, elements per lane (shift depth).
- N, 2, element width in bits.
- D, 3, drain cycles after the last enable (array pipeline latency); D>=0.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  high in IDLE only
- in_data  in  R*S*N  operand block; lane r occupies bits [(r+1)*S*N-1 : r*S*N]
- load  out  R  per-lane load strobe, drives each feeder lane's load/reset input
- load_data  out  R*S*N  registered copy of in_data captured at accept
- enable  out  R  per-lane shift enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, LOAD, STREAM, DRAIN, DONE. Outputs are Moore-decoded from registered state and counter.
- Reset values: state=IDLE, counter=0, load=0, enable=0, done=0, busy=0, ready=1, load_data=0.
- rst asserted in any state, including mid-stream: next cycle IDLE, all strobes 0; load_data cleared.
- IDLE: if start=1, capture in_data into load_data and go to LOAD. Otherwise stay.
- LOAD: exactly one cycle; load={R{1'b1}}; enable=0. Next state STREAM, counter=0.
- STREAM: lasts S+R-1 cycles, counter c=0..S+R-2.
  - enable[r]=1 iff r<=c<r+S.
  - Lane r therefore sees exactly S enables.
  - Last cycle (c=S+R-2) goes to DRAIN with counter=0, or directly to DONE if D=0.
- DRAIN: D cycles, enable=0, load=0.
- DONE: one cycle, done=1, busy=1. Next state IDLE.
- start while not ready is ignored, not queued. in_data is don't-care outside the accept cycle.
- Latency for the default parameters (R=2, S=8, D=3):
  - start accepted at cycle t0.
  - load at t0+1.
  - first enable at t0+2, last enable at t0+10.
  - done at t0+14.
  - ready again at t0+15.
- Counter width: clog2(max(S+R-1, D)+1). No wrap inside an operation.

Optional Feature:
- Macro SKEW_FEED_OPCOUNT_EN.
- Defined:
  - Adds output op_count [15:0].
  - Increments by 1 on each cycle done=1, wrapping 16'hFFFF -> 0.
  - Cleared by rst.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package skew_feed_pkg holds:
  - state enum (IDLE=0, LOAD=1, STREAM=2, DRAIN=3, DONE=4, 3-bit encoding);
  - localparam STREAM_LEN=S+R-1;
  - counter width function.
- One sub-module is natural: skew_window_cmp, a per-lane comparator producing enable[r] from (c, r, S).
  - Instantiate it R times with a generate loop.

Test Plan:
- Reset then idle for 5 cycles -> ready=1, busy=0, load=0, enable=0, done=0 throughout.
- R=2,S=8,D=3; start at t0 with in_data=32'hA5A5_3C3C -> load=2'b11 and load_data=32'hA5A5_3C3C at t0+1. Check the full schedule:
  - enable=01 at t0+2;
  - enable=11 for t0+3..t0+9;
  - enable=10 at t0+10;
  - done at t0+14;
  - ready at t0+15.
- Count enables per lane over one operation -> exactly 8 each. Lane1's first enable is exactly 1 cycle after lane0's.
- start held high continuously -> second accept occurs at t0+15, capturing the current in_data. No start is accepted between t0+1 and t0+14.
- rst pulsed at t0+6 (mid-STREAM) -> at t0+7 state IDLE, enable=0, ready=1, load_data=0. A new start then runs a full, correct schedule.
- D=0 build -> done at t0+11 (directly after the last enable). With SKEW_FEED_OPCOUNT_EN, three operations -> op_count=3, and rst returns it to 0.
